fetch_sequencer: RTL and testbench

Instruction-fetch controller sitting between the core's PC logic and the combinational instruction memory. It owns the program counter and drives the memory's byte-offset select. It registers each returned word into a one-entry output stage with a valid/ready handshake, and handles branch redirects with a flush. It latches a sticky fault on a misaligned redirect target.

---
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, captures imem words into a valid/ready output stage.
// Optional debug read port enabled by defining FETCH_DEBUG_PORT_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [31:0]      imem_sel,
    input  logic [31:0]      imem_data,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    input  logic             instr_ready,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_cnt
`ifdef FETCH_DEBUG_PORT_EN
    ,
    input  logic             dbg_req,
    input  logic [31:0]      dbg_addr,
    output logic             dbg_ack,
    output logic [31:0]      dbg_data
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        capture;

`ifdef FETCH_DEBUG_PORT_EN
    logic dbg_grant;

    // Debug only borrows the memory on edges where the fetch stage would not capture anyway.
    assign dbg_grant = (state == S_RUN) & dbg_req & (~run | (instr_valid & ~instr_ready));
    assign imem_sel  = dbg_grant ? dbg_addr : pc;
    assign capture   = run & (~instr_valid | instr_ready) & ~dbg_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_ack  <= 1'b0;
            dbg_data <= '0;
        end else begin
            dbg_ack <= dbg_grant;
            if (dbg_grant) begin
                dbg_data <= imem_data;
            end
        end
    end
`else
    assign imem_sel = pc;
    assign capture  = run & (~instr_valid | instr_ready);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fault       <= 1'b0;
            fetch_cnt   <= '0;
        end else begin
            // Counted even when a redirect flushes the stage: the consumer already took it.
            if (instr_valid & instr_ready) begin
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                        state       <= S_FAULT;
                        fault       <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (redirect) begin
                        pc          <= redirect_pc;
                        instr_valid <= 1'b0;
                    end else if (capture) begin
                        instr       <= imem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                    end else if (instr_valid && instr_ready && !run) begin
                        instr_valid <= 1'b0;
                    end
                end
                S_FAULT: begin
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                end
                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_sequencer;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [31:0]   imem_sel;
    logic [31:0]   imem_data;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_ready = 1'b0;
    logic          fault;
    logic [CW-1:0] fetch_cnt;
`ifdef FETCH_DEBUG_PORT_EN
    logic          dbg_req = 1'b0;
    logic [31:0]   dbg_addr = '0;
    logic          dbg_ack;
    logic [31:0]   dbg_data;
    bit            m_ack;
    logic [31:0]   m_ddata;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_started, m_fault, m_valid;
    logic [31:0] m_pc, m_ipc;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign imem_data = mem(imem_sel);

    fetch_sequencer #(.RESET_PC(32'd0), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_sel(imem_sel), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .fault(fault),
        .fetch_cnt(fetch_cnt)
`ifdef FETCH_DEBUG_PORT_EN
        , .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_fault = 0; m_valid = 0;
        m_pc = 32'd0; m_ipc = 32'd0; m_cnt = 0;
`ifdef FETCH_DEBUG_PORT_EN
        m_ack = 0; m_ddata = '0;
`endif
    endtask

    // Called just after a falling edge: drive, predict, clock, check.
    task automatic step(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc);
        bit fire;
        bit grant;
        run = r; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
        grant = 0;
`ifdef FETCH_DEBUG_PORT_EN
        grant = m_started && !m_fault && dbg_req && (!r || (m_valid && !rdy));
`endif
        #1;
`ifdef FETCH_DEBUG_PORT_EN
        chk("imem_sel", imem_sel, grant ? dbg_addr : m_pc);
        m_ack = grant;
        if (grant) m_ddata = mem(dbg_addr);
`else
        chk("imem_sel", imem_sel, m_pc);
`endif
        fire = m_valid && rdy;
        if (!m_started) begin
            m_started = 1;
        end else if (!m_fault) begin
            if (rd && rpc[1:0] != 2'b00) begin
                m_fault = 1; m_valid = 0;
            end else if (rd) begin
                m_pc = rpc; m_valid = 0;
            end else if (r && (!m_valid || rdy) && !grant) begin
                m_ipc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1;
            end else if (fire) begin
                m_valid = 0;
            end
        end
        if (fire) m_cnt = (m_cnt + 1) % (1 << CW);
        @(posedge clk);
        @(negedge clk);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        chk("fetch_cnt", {{(32-CW){1'b0}}, fetch_cnt}, m_cnt);
        if (m_valid) begin
            chk("instr_pc", instr_pc, m_ipc);
            chk("instr", instr, mem(m_ipc));
        end
`ifdef FETCH_DEBUG_PORT_EN
        chk("dbg_ack", {31'd0, dbg_ack}, {31'd0, m_ack});
        chk("dbg_data", dbg_data, m_ddata);
`endif
    endtask

    // Asynchronous reset mid-cycle, released on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_cnt", {{(32-CW){1'b0}}, fetch_cnt}, 32'd0);
        chk("rst_sel", imem_sel, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Start-up: IDLE edge, then A/0, B/4, C/8 on consecutive cycles.
        step(1, 1, 0, 0);
        chk("idle_no_fetch", {31'd0, instr_valid}, 32'd0);
        step(1, 1, 0, 0);
        chk("first_pc", instr_pc, 32'd0);
        step(1, 1, 0, 0);
        chk("second_pc", instr_pc, 32'd4);
        step(1, 1, 0, 0);
        chk("third_pc", instr_pc, 32'd8);
        step(1, 1, 0, 0);
        chk("cnt_after_3", {{(32-CW){1'b0}}, fetch_cnt}, 32'd3);

        // Backpressure: stage holds while ready is low.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);

        // Advance until pc reaches 20, then redirect with an unaccepted word in the stage.
        for (int i = 0; i < 10 && m_pc != 32'd20; i++) step(1, 1, 0, 0);
        chk("pc_at_20", imem_sel, 32'd20);
        step(1, 0, 1, 32'd8);
        chk("bubble", {31'd0, instr_valid}, 32'd0);
        step(1, 1, 0, 0);
        chk("target_pc", instr_pc, 32'd8);
        step(1, 1, 0, 0);
        chk("target_next", instr_pc, 32'd12);

        // PC wrap at the top of the address space.
        step(1, 1, 1, 32'hFFFFFFF8);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

        // Counter wrap: at least 16 more accepts.
        for (int i = 0; i < 18; i++) step(1, 1, 0, 0);

`ifdef FETCH_DEBUG_PORT_EN
        // Debug read while the stage is stalled.
        step(1, 0, 0, 0);
        dbg_req = 1'b1; dbg_addr = 32'd16;
        step(1, 0, 0, 0);
        dbg_req = 1'b0;
        step(1, 0, 0, 0);
        chk("dbg_data16", dbg_data, mem(32'd16));
`endif

        // Randomized traffic with occasional aligned redirects.
        for (int i = 0; i < 400; i++) begin
`ifdef FETCH_DEBUG_PORT_EN
            dbg_req = ($urandom_range(0, 3) == 0);
            dbg_addr = $urandom & 32'hFFFF_FFFC;
`endif
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC);
        end
`ifdef FETCH_DEBUG_PORT_EN
        dbg_req = 1'b0;
`endif

        // Misaligned redirect: terminal fault, later redirects ignored.
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h00000006);
        chk("fault_set", {31'd0, fault}, 32'd1);
        step(1, 1, 1, 32'h00000040);
        step(1, 1, 0, 0);
        chk("fault_sticky", {31'd0, fault}, 32'd1);

        do_reset();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("post_reset_pc", instr_pc, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
